muldiv_controller: RTL and testbench

Sequencer for the CPU's shared multiply/divide resource. It accepts a one-cycle `start` from the main control FSM and runs either a signed iterative Booth multiply or a signed restoring divide on the A/B operands. It then produces Hi/Lo results with a single load strobe for the Hi and Lo registers. `busy` and `done` let the control FSM stall for as many cycles as the operation takes, and a divide-by-zero flag goes to exception handling.

---
 rtl/muldiv_controller.sv | 226 ++++++++++++++++++++++
 tb/tb_muldiv_controller.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | muldiv_controller: sequencer for the shared signed multiply/divide unit.  |
// | Booth multiply or restoring divide producing Hi/Lo with a load strobe.    |
// | Option: MULDIV_FAST_MUL_EN selects a single-cycle combinational multiply. |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module muldiv_controller #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             hi_lo_load,
   output logic [WIDTH-1:0] hi_res,
   output logic [WIDTH-1:0] lo_res,
   output logic             divby0
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_MUL_RUN = 3'd1,
      S_DIV_RUN = 3'd2,
      S_DIV_FIX = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic             a_neg_q, a_neg_d;
   logic             q_neg_q, q_neg_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             load_q, load_d;
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   rem_sh, diff;

   assign a_mag  = operand_a[WIDTH-1] ? -operand_a : operand_a;
   assign b_mag  = operand_b[WIDTH-1] ? -operand_b : operand_b;
   // Divisor magnitude is at most 2^(WIDTH-1), so one extra bit holds the trial sign.
   assign rem_sh = {rem_q, quo_q[WIDTH-1]};
   assign diff   = rem_sh - {1'b0, b_q};

`ifdef MULDIV_FAST_MUL_EN
   logic signed [2*WIDTH-1:0] prod;
   assign prod = $signed(a_q) * $signed(b_q);
`else
   logic [2*WIDTH:0] acc_q, acc_d;
   logic [WIDTH:0]   hi_ext, m_ext, booth_sum;
   logic [2*WIDTH:0] booth_next;

   // Upper half is sign-extended by one bit so subtracting the most negative
   // multiplicand cannot overflow before the shift.
   assign hi_ext = {acc_q[2*WIDTH], acc_q[2*WIDTH:WIDTH+1]};
   assign m_ext  = {a_q[WIDTH-1], a_q};
   always_comb begin
      case (acc_q[1:0])
         2'b01:   booth_sum = hi_ext + m_ext;
         2'b10:   booth_sum = hi_ext - m_ext;
         default: booth_sum = hi_ext;
      endcase
   end
   assign booth_next = {booth_sum, acc_q[WIDTH:1]};
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      a_neg_d = a_neg_q;
      q_neg_d = q_neg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      load_d  = 1'b0;
      dz_d    = 1'b0;
`ifndef MULDIV_FAST_MUL_EN
      acc_d   = acc_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               cnt_d   = CW'(WIDTH);
               a_d     = operand_a;
               b_d     = op ? b_mag : operand_b;
               rem_d   = '0;
               quo_d   = a_mag;
               a_neg_d = operand_a[WIDTH-1];
               q_neg_d = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
`ifndef MULDIV_FAST_MUL_EN
               acc_d   = {{WIDTH{1'b0}}, operand_b, 1'b0};
`endif
               if (!op) begin
                  state_d = S_MUL_RUN;
               end else if (operand_b == '0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  dz_d    = 1'b1;
               end else begin
                  state_d = S_DIV_RUN;
               end
            end
         end
         S_MUL_RUN: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
`ifdef MULDIV_FAST_MUL_EN
               hi_d    = prod[2*WIDTH-1:WIDTH];
               lo_d    = prod[WIDTH-1:0];
               state_d = S_DONE;
               done_d  = 1'b1;
               load_d  = 1'b1;
`else
               acc_d = booth_next;
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  hi_d    = booth_next[2*WIDTH:WIDTH+1];
                  lo_d    = booth_next[WIDTH:1];
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  load_d  = 1'b1;
               end
`endif
            end
         end
         S_DIV_RUN: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               if (!diff[WIDTH]) begin
                  rem_d = diff[WIDTH-1:0];
                  quo_d = {quo_q[WIDTH-2:0], 1'b1};
               end else begin
                  rem_d = rem_sh[WIDTH-1:0];
                  quo_d = {quo_q[WIDTH-2:0], 1'b0};
               end
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) state_d = S_DIV_FIX;
            end
         end
         S_DIV_FIX: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               lo_d    = q_neg_q ? -quo_q : quo_q;
               hi_d    = a_neg_q ? -rem_q : rem_q;
               state_d = S_DONE;
               done_d  = 1'b1;
               load_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_MUL_RUN) || (state_d == S_DIV_RUN) || (state_d == S_DIV_FIX);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         a_neg_q <= 1'b0;
         q_neg_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         load_q  <= 1'b0;
         dz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
`ifndef MULDIV_FAST_MUL_EN
         acc_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         a_neg_q <= a_neg_d;
         q_neg_q <= q_neg_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         load_q  <= load_d;
         dz_q    <= dz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
`ifndef MULDIV_FAST_MUL_EN
         acc_q   <= acc_d;
`endif
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign hi_lo_load = load_q;
   assign divby0     = dz_q;
   assign hi_res     = hi_q;
   assign lo_res     = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_muldiv_controller: directed vector bench for muldiv_controller.        |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_muldiv_controller;

`ifdef MULDIV_FAST_MUL_EN
   localparam int   MUL_CYC  = 2;
   localparam logic ABORT_OP = 1'b1;
`else
   localparam int   MUL_CYC  = 33;
   localparam logic ABORT_OP = 1'b0;
`endif
   localparam int DIV_CYC = 34;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        op    = 1'b0;
   logic [31:0] operand_a = '0;
   logic [31:0] operand_b = '0;
   logic        abort = 1'b0;
   logic        busy, done, hi_lo_load, divby0;
   logic [31:0] hi_res, lo_res;

   muldiv_controller #(.WIDTH(32)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op),
      .operand_a(operand_a), .operand_b(operand_b), .abort(abort),
      .busy(busy), .done(done), .hi_lo_load(hi_lo_load),
      .hi_res(hi_res), .lo_res(lo_res), .divby0(divby0)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic        op;
      logic [31:0] a, b, hi, lo;
      int          cyc;
      logic        load, dz;
   } vec_t;
   vec_t vt[12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Start is driven in cycle 0; on return the bench sits in cycle 1.
   task automatic launch(input logic o, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1; op = o; operand_a = a; operand_b = b;
      tick();
      start = 1'b0; op = 1'b0; operand_a = '0; operand_b = '0;
   endtask

   task automatic wait_done(input int first, output int cyc);
      cyc = first;
      while (!done && cyc < first + 100) begin
         tick();
         cyc++;
      end
      if (!done) cyc = -1;
   endtask

   initial begin
      int c;
      logic seen;

      vt[0]  = '{1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, MUL_CYC, 1'b1, 1'b0};
      vt[1]  = '{1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_CYC, 1'b1, 1'b0};
      vt[2]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_CYC, 1'b1, 1'b0};
      vt[3]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MUL_CYC, 1'b1, 1'b0};
      vt[4]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, MUL_CYC, 1'b1, 1'b0};
      vt[5]  = '{1'b0, 32'h12345678, 32'h00000100, 32'h00000012, 32'h34567800, MUL_CYC, 1'b1, 1'b0};
      vt[6]  = '{1'b1, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, DIV_CYC, 1'b1, 1'b0};
      vt[7]  = '{1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DIV_CYC, 1'b1, 1'b0};
      vt[8]  = '{1'b1, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, DIV_CYC, 1'b1, 1'b0};
      vt[9]  = '{1'b1, 32'h00000003, 32'h00000005, 32'h00000003, 32'h00000000, DIV_CYC, 1'b1, 1'b0};
      vt[10] = '{1'b1, 32'h00000005, 32'h00000000, 32'h00000003, 32'h00000000, 1,       1'b0, 1'b1};
      vt[11] = '{1'b0, 32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 32'h80000000, MUL_CYC, 1'b1, 1'b0};

      // Reset state
      tick(); tick();
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_load", 64'(hi_lo_load), 64'(0));
      chk("rst_dz",   64'(divby0), 64'(0));
      chk("rst_hi",   64'(hi_res), 64'(0));
      chk("rst_lo",   64'(lo_res), 64'(0));
      reset = 1'b1;
      tick();

      for (int i = 0; i < 12; i++) begin
         launch(vt[i].op, vt[i].a, vt[i].b);
         chk($sformatf("v%0d_busy1", i), 64'(busy), 64'(!vt[i].dz));
         wait_done(1, c);
         chk($sformatf("v%0d_cyc", i),  64'(c), 64'(vt[i].cyc));
         chk($sformatf("v%0d_hi", i),   64'(hi_res), 64'(vt[i].hi));
         chk($sformatf("v%0d_lo", i),   64'(lo_res), 64'(vt[i].lo));
         chk($sformatf("v%0d_load", i), 64'(hi_lo_load), 64'(vt[i].load));
         chk($sformatf("v%0d_dz", i),   64'(divby0), 64'(vt[i].dz));
         tick();
         chk($sformatf("v%0d_done_pulse", i), 64'({done, busy, divby0}), 64'(0));
      end

      // Back-to-back launch from DONE, with a start during the run that must be ignored
      launch(1'b0, 32'h7, 32'hFFFFFFFD);
      wait_done(1, c);
      chk("b2b_first_cyc", 64'(c), 64'(MUL_CYC));
      launch(1'b0, 32'h3, 32'h5);
      chk("b2b_busy", 64'({busy, done}), 64'(2'b10));
      start = 1'b1; op = 1'b1; operand_a = 32'h5; operand_b = 32'h0;
      tick();
      start = 1'b0; op = 1'b0; operand_a = '0; operand_b = '0;
      wait_done(2, c);
      chk("b2b_cyc", 64'(c), 64'(MUL_CYC));
      chk("b2b_hi",  64'(hi_res), 64'(32'h0));
      chk("b2b_lo",  64'(lo_res), 64'(32'hF));
      chk("b2b_dz",  64'(divby0), 64'(0));
      tick();

      // Abort at cycle 10 (with a simultaneous start), relaunch at cycle 12
      launch(ABORT_OP, 32'h2, 32'h3);
      c = 1;
      seen = 1'b0;
      while (c < 10) begin
         if (done) seen = 1'b1;
         tick();
         c++;
      end
      abort = 1'b1; start = 1'b1; op = 1'b0; operand_a = 32'h9; operand_b = 32'h9;
      tick();
      abort = 1'b0; start = 1'b0; operand_a = '0; operand_b = '0;
      chk("abort_no_done", 64'({seen, done, hi_lo_load}), 64'(0));
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_hold", 64'({hi_res, lo_res}), {32'h0, 32'hF});
      tick();
      chk("abort_idle", 64'({busy, done}), 64'(0));
      launch(1'b0, 32'h6, 32'hFFFFFFF9);
      wait_done(13, c);
      chk("abort_relaunch_cyc", 64'(c), 64'(12 + MUL_CYC));
      chk("abort_relaunch_res", {hi_res, lo_res}, {32'hFFFFFFFF, 32'hFFFFFFD6});
      tick();

      // Reset asserted in cycle 20 of a divide
      launch(1'b1, 32'h64, 32'h7);
      for (int k = 1; k < 20; k++) tick();
      reset = 1'b0;
      #1;
      chk("midrst_flags", 64'({busy, done, hi_lo_load, divby0}), 64'(0));
      chk("midrst_res", {hi_res, lo_res}, 64'(0));
      tick();
      reset = 1'b1;
      tick();
      chk("midrst_idle", 64'({busy, done}), 64'(0));

      launch(1'b0, 32'h7, 32'hFFFFFFFD);
      wait_done(1, c);
      chk("final_cyc", 64'(c), 64'(MUL_CYC));
      chk("final_res", {hi_res, lo_res}, {32'hFFFFFFFF, 32'hFFFFFFEB});
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
